multi_sequencer: RTL and testbench

//  Control FSM for the 4-bit shift-add multiplier. Takes a START request, loads the

---
 rtl/multi_pkg.sv | 12 +
 rtl/multi_step_counter.sv | 35 +++
 rtl/multi_sequencer.sv | 96 +++++++++
 tb/tb_multi_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_pkg.sv
// Shared encodings and default sizing for the shift-add multiplier sequencer.
package multi_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/multi_step_counter.sv
// Step counter for the multiplier sequencer: synchronous clear/increment,
// terminal count at WIDTH and a flag for values that can never be legal.
module multi_step_counter
    import multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc,
    output logic             illegal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc      = (cnt == LAST);
    assign illegal = (cnt > LAST);

endmodule

// File: rtl/multi_sequencer.sv
// Control FSM for the 4-bit shift-add multiplier: load, one step per multiplier
// bit, then a one-cycle DONE pulse. ABORT wins over every transition.
module multi_sequencer
    import multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             MPLR_BIT,
    output logic             LOAD,
    output logic             STEP_EN,
    output logic             ADD_EN,
    output logic [CNT_W-1:0] cnt,
    output logic             BUSY,
    output logic             DONE
);

    if (WIDTH < 1 || WIDTH >= (1 << CNT_W)) begin : g_bad_width
        $fatal(1, "multi_sequencer: WIDTH must be in 1..2**CNT_W-1");
    end

    logic [1:0] state;
    logic [1:0] state_next;
    logic       cnt_clear;
    logic       cnt_inc;
    logic       cnt_tc;
    logic       cnt_illegal;
    logic       cnt_bad;

    multi_step_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_step_counter (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .cnt    (cnt),
        .tc     (cnt_tc),
        .illegal(cnt_illegal)
    );

    // cnt must be 1..WIDTH inside CALC and 0 everywhere else.
    assign cnt_bad = cnt_illegal || ((state == S_CALC) == (cnt == '0));

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        if (ABORT || cnt_bad) begin
            state_next = S_IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                S_IDLE: if (START) state_next = S_LOAD;
                S_LOAD: begin
                    state_next = S_CALC;
                    cnt_inc    = 1'b1;
                end
                S_CALC: begin
                    if (cnt_tc) begin
                        state_next = S_DONE;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                S_DONE: state_next = S_IDLE;
                default: begin
                    state_next = S_IDLE;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign LOAD    = (state == S_LOAD);
    assign STEP_EN = (state == S_CALC);
    assign ADD_EN  = STEP_EN & MPLR_BIT;
    assign BUSY    = (state != S_IDLE);
    assign DONE    = (state == S_DONE);

endmodule

// File: tb/tb_multi_sequencer.sv
// Directed bench for multi_sequencer: table-driven single job plus hand-written
// reset, held-START, ABORT and WIDTH=7 sequences.
module tb_multi_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       MPLR_BIT = 1'b0;
    logic       START7 = 1'b0;

    logic       LOAD, STEP_EN, ADD_EN, BUSY, DONE;
    logic [2:0] cnt;
    logic       LOAD7, STEP_EN7, ADD_EN7, BUSY7, DONE7;
    logic [2:0] cnt7;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    multi_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MPLR_BIT(MPLR_BIT),
        .LOAD(LOAD), .STEP_EN(STEP_EN), .ADD_EN(ADD_EN), .cnt(cnt),
        .BUSY(BUSY), .DONE(DONE)
    );

    multi_sequencer #(.WIDTH(7), .CNT_W(3)) dut7 (
        .CLK(CLK), .RST(RST), .START(START7), .ABORT(1'b0), .MPLR_BIT(1'b1),
        .LOAD(LOAD7), .STEP_EN(STEP_EN7), .ADD_EN(ADD_EN7), .cnt(cnt7),
        .BUSY(BUSY7), .DONE(DONE7)
    );

    typedef struct {
        logic       start;
        logic       abort;
        logic       mplr;
        logic       load;
        logic       step;
        logic       add;
        logic [2:0] cnt;
        logic       busy;
        logic       done;
    } vec_t;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Packed view {LOAD, STEP_EN, ADD_EN, cnt, BUSY, DONE}.
    task automatic check_outs(input string name, input logic l, input logic s, input logic a,
                              input logic [2:0] c, input logic b, input logic d);
        check(name, {8'h0, LOAD, STEP_EN, ADD_EN, cnt, BUSY, DONE}, {8'h0, l, s, a, c, b, d});
    endtask

    // Inputs change just after the rising edge; outputs are read on the falling edge.
    task automatic drive(input logic s, input logic a, input logic m);
        @(posedge CLK);
        #1;
        START    = s;
        ABORT    = a;
        MPLR_BIT = m;
        @(negedge CLK);
    endtask

    vec_t vecs [9];
    int   acc;
    int   prev_done;
    int   n_done;
    int   lat;
    int   steps;
    int   exp_c;
    logic seen_done;

    initial begin
        // start, abort, mplr | load, step, add, cnt, busy, done
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

        // Power-on reset
        repeat (2) @(negedge CLK);
        check_outs("reset_state", 0, 0, 0, 3'd0, 0, 0);
        RST = 1'b1;
        drive(0, 0, 0);
        check_outs("idle_after_reset", 0, 0, 0, 3'd0, 0, 0);

        // Single job, multiplicand 13, multiplier 4'b1101 fed LSB first.
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].mplr);
            check_outs($sformatf("vec%0d", i), vecs[i].load, vecs[i].step, vecs[i].add,
                       vecs[i].cnt, vecs[i].busy, vecs[i].done);
            if (ADD_EN === 1'b1 && cnt != 3'd0) acc += 13 << (int'(cnt) - 1);
        end
        check("product_13x13", 16'(acc), 16'd169);

        // Async reset in the middle of CALC
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 1);
        check("pre_reset_cnt", {13'h0, cnt}, 16'd3);
        RST = 1'b0;
        #1;
        check_outs("async_reset_mid_calc", 0, 0, 0, 3'd0, 0, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        drive(0, 0, 0);
        check_outs("idle_after_release", 0, 0, 0, 3'd0, 0, 0);

        // START held high: DONE every WIDTH+3 cycles
        prev_done = -1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1, 0, 0);
            if (DONE === 1'b1) begin
                if (prev_done >= 0) check("done_spacing", 16'(i - prev_done), 16'd7);
                prev_done = i;
                n_done++;
            end
        end
        check("held_done_count", 16'(n_done), 16'd4);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0);
            if (BUSY === 1'b0) break;
        end
        check("drain_busy", {15'h0, BUSY}, 16'd0);

        // ABORT while cnt=2
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 1, 1);
        check("abort_cycle_cnt", {13'h0, cnt}, 16'd2);
        drive(0, 0, 1);
        check_outs("abort_to_idle", 0, 0, 0, 3'd0, 0, 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1);
            if (DONE !== 1'b0) n_done++;
        end
        check("no_done_after_abort", 16'(n_done), 16'd0);

        drive(1, 0, 0);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0);
            if (DONE === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("post_abort_done_latency", 16'(lat), 16'd6);

        drive(1, 1, 0);
        drive(0, 0, 0);
        check_outs("abort_with_start_idle", 0, 0, 0, 3'd0, 0, 0);

        // WIDTH=7 instance: cnt climbs 1..7 without wrapping, then DONE
        @(posedge CLK);
        #1;
        START7 = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        START7 = 1'b0;
        @(negedge CLK);
        check("w7_load", {15'h0, LOAD7}, 16'd1);
        steps = 0;
        exp_c = 1;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (STEP_EN7 === 1'b1) begin
                check($sformatf("w7_cnt_step%0d", exp_c), {13'h0, cnt7}, 16'(exp_c));
                exp_c++;
                steps++;
            end
            if (DONE7 === 1'b1) begin
                seen_done = 1'b1;
                check("w7_cnt_in_done", {13'h0, cnt7}, 16'd0);
                break;
            end
        end
        check("w7_step_count", 16'(steps), 16'd7);
        check("w7_done_seen", {15'h0, seen_done}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
